mult_normalizer_pipe: RTL and testbench

- Multi-lane, pipelined successor of the single-lane combinational multiplier normalizer.
- Takes raw product exponent/mantissa pairs from the MX multiplier array and produces normalized (exponent, mantissa, flags) results.
- Handles product-mantissa overflow (bit MSB set), zero, exponent overflow and underflow.
- Sits between the multiplier array and the accumulator, with valid/ready backpressure.

---
 rtl/mult_normalizer_pipe_if.sv | 29 ++
 rtl/mult_normalizer_pipe.sv | 174 +++++++++++++++++
 tb/tb_mult_normalizer_pipe.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_normalizer_pipe_if.sv
// Valid/ready handshake and per-lane data bus between the multiplier array,
// the normalizer pipeline and the accumulator.
interface mult_normalizer_pipe_if #(
  parameter int LANES   = 4,
  parameter int IN_E_W  = 9,
  parameter int IN_M_W  = 16,
  parameter int OUT_E_W = 8,
  parameter int OUT_M_W = 7
);
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IN_E_W-1:0]    in_e;
  logic [LANES*IN_M_W-1:0]    in_m;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*OUT_E_W-1:0]   out_e;
  logic [LANES*OUT_M_W-1:0]   out_m;
  logic [LANES*3-1:0]         out_flags;

  modport slave (
    input  in_valid, in_e, in_m, out_ready,
    output in_ready, out_valid, out_e, out_m, out_flags
  );

  modport master (
    output in_valid, in_e, in_m, out_ready,
    input  in_ready, out_valid, out_e, out_m, out_flags
  );
endinterface

// File: rtl/mult_normalizer_pipe.sv
// Two-stage multi-lane normalizer for MX multiplier products (leading-one
// detect, then shift/adjust/special cases). MULT_NORM_ROUND_NEAREST_EN selects RNE, else truncate.
module mult_normalizer_pipe #(
  parameter int LANES   = 4,
  parameter int IN_E_W  = 9,
  parameter int IN_M_W  = 16,
  parameter int OUT_E_W = 8,
  parameter int OUT_M_W = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_normalizer_pipe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [15:0]          ovf_cnt
);

  localparam int P_W   = $clog2(IN_M_W);
  localparam int X_W   = IN_E_W + 2;
  localparam int EXT_W = IN_M_W + 1;
  localparam int C_W   = $clog2(LANES + 1);
  localparam logic signed [X_W-1:0] E_MAX  = X_W'((1 << OUT_E_W) - 1);
  localparam logic signed [X_W-1:0] E_BIAS = X_W'(IN_M_W - 2);
  localparam logic signed [X_W-1:0] E_ZERO = '0;

  logic                      s1_v_q, s1_v_d;
  logic [LANES*IN_E_W-1:0]   s1_e_q, s1_e_d;
  logic [LANES*IN_M_W-1:0]   s1_m_q, s1_m_d;
  logic [P_W-1:0]            s1_p_q [LANES];
  logic [P_W-1:0]            s1_p_d [LANES];

  logic                      out_valid_q, out_valid_d;
  logic [LANES*OUT_E_W-1:0]  out_e_q, out_e_d;
  logic [LANES*OUT_M_W-1:0]  out_m_q, out_m_d;
  logic [LANES*3-1:0]        out_flags_q, out_flags_d;
  logic [15:0]               ovf_cnt_q, ovf_cnt_d;

  logic s2_adv, s1_load, retire;

  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_v_q || s2_adv);
  assign s1_load      = bus.in_valid && bus.in_ready;
  assign retire       = out_valid_q && bus.out_ready;

  always_comb begin
    s1_v_d = s1_v_q;
    s1_e_d = s1_e_q;
    s1_m_d = s1_m_q;
    s1_p_d = s1_p_q;
    if (s1_load) begin
      s1_v_d = 1'b1;
      s1_e_d = bus.in_e;
      s1_m_d = bus.in_m;
    end else if (s2_adv) begin
      s1_v_d = 1'b0;
    end
    for (int unsigned l = 0; l < LANES; l++) begin
      if (s1_load) begin
        s1_p_d[l] = '0;
        for (int unsigned b = 0; b < IN_M_W; b++) begin
          if (bus.in_m[l*IN_M_W + b]) s1_p_d[l] = P_W'(b);
        end
      end
    end
  end

  always_comb begin : s2_comb
    logic [IN_E_W-1:0]       e_in;
    logic [IN_M_W-1:0]       m_in;
    logic [P_W-1:0]          shl;
    logic signed [X_W-1:0]   e_x;
    logic signed [X_W-1:0]   e_r;
    logic                    lead;
    logic [OUT_M_W-1:0]      frac;
    logic [OUT_M_W-1:0]      frac_r;
    logic [2:0]              fl;
    logic [OUT_E_W-1:0]      oe;
    logic [OUT_M_W-1:0]      om;
`ifdef MULT_NORM_ROUND_NEAREST_EN
    logic [EXT_W-1:0]        ext;
    logic                    guard;
    logic                    sticky;
    logic                    carry;
`endif
    out_valid_d = out_valid_q;
    out_e_d     = out_e_q;
    out_m_d     = out_m_q;
    out_flags_d = out_flags_q;
    if (s2_adv) out_valid_d = s1_v_q;
    for (int unsigned l = 0; l < LANES; l++) begin
      e_in = s1_e_q[l*IN_E_W +: IN_E_W];
      m_in = s1_m_q[l*IN_M_W +: IN_M_W];
      shl  = P_W'(IN_M_W - 1) - s1_p_q[l];
      e_x  = X_W'(e_in) + X_W'(s1_p_q[l]) - E_BIAS;
      // Mantissa is extended by one zero LSB and shifted so the leading one
      // sits at the top; this covers the right-shift-by-one (MSB set) case too.
`ifdef MULT_NORM_ROUND_NEAREST_EN
      ext    = {m_in, 1'b0} << shl;
      lead   = ext[EXT_W-1];
      frac   = ext[EXT_W-2 -: OUT_M_W];
      guard  = ext[EXT_W-2-OUT_M_W];
      sticky = |ext[EXT_W-3-OUT_M_W:0];
      {carry, frac_r} = {1'b0, frac} + (OUT_M_W+1)'(guard && (sticky || frac[0]));
      e_r    = e_x + X_W'(carry);
`else
      {lead, frac} = (OUT_M_W+1)'(({m_in, 1'b0} << shl) >> (EXT_W - OUT_M_W - 1));
      frac_r = frac;
      e_r    = e_x;
`endif
      fl = 3'b000;
      oe = '0;
      om = '0;
      if (e_in[IN_E_W-1]) begin
        fl = 3'b100;
        oe = '1;
      end else if (!lead) begin
        fl = 3'b001;
      end else if (e_x <= E_ZERO) begin
        fl = 3'b010;
      end else if (e_r >= E_MAX) begin
        fl = 3'b100;
        oe = '1;
      end else begin
        oe = e_r[OUT_E_W-1:0];
        om = frac_r;
      end
      if (s2_adv && s1_v_q) begin
        out_e_d[l*OUT_E_W +: OUT_E_W] = oe;
        out_m_d[l*OUT_M_W +: OUT_M_W] = om;
        out_flags_d[l*3 +: 3]         = fl;
      end
    end
  end

  always_comb begin : cnt_comb
    logic [C_W-1:0] nov;
    logic [16:0]    sum;
    nov = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      nov = nov + C_W'(out_flags_q[l*3 + 2]);
    end
    sum       = {1'b0, ovf_cnt_q} + 17'(nov);
    ovf_cnt_d = ovf_cnt_q;
    if (cnt_clr)     ovf_cnt_d = '0;
    else if (retire) ovf_cnt_d = sum[16] ? '1 : sum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_flags_q <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      out_valid_q <= out_valid_d;
      out_e_q     <= out_e_d;
      out_m_q     <= out_m_d;
      out_flags_q <= out_flags_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
    s1_e_q <= s1_e_d;
    s1_m_q <= s1_m_d;
    s1_p_q <= s1_p_d;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_e     = out_e_q;
  assign bus.out_m     = out_m_q;
  assign bus.out_flags = out_flags_q;
  assign ovf_cnt       = ovf_cnt_q;

endmodule

// File: tb/tb_mult_normalizer_pipe.sv
// Scoreboard bench for mult_normalizer_pipe: directed vectors push expected
// beats; a negedge monitor pops and compares retired beats and ovf_cnt.
module tb_mult_normalizer_pipe;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;
  logic [15:0] ovf_cnt;

  always #5 clk = ~clk;

  mult_normalizer_pipe_if #(.LANES(4), .IN_E_W(9), .IN_M_W(16), .OUT_E_W(8), .OUT_M_W(7)) bus ();

  mult_normalizer_pipe #(.LANES(4), .IN_E_W(9), .IN_M_W(16), .OUT_E_W(8), .OUT_M_W(7)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .cnt_clr (cnt_clr),
    .ovf_cnt (ovf_cnt)
  );

`ifdef MULT_NORM_ROUND_NEAREST_EN
  localparam logic [6:0] M_40C0 = 7'h02;
  localparam logic [7:0] E_7FFF = 8'd128;
  localparam logic [6:0] M_7FFF = 7'h00;
  localparam logic [6:0] M_5A5A = 7'h35;
  localparam logic [7:0] E_HI   = 8'd255;
  localparam logic [6:0] M_HI   = 7'h00;
  localparam logic [2:0] F_HI   = 3'b100;
`else
  localparam logic [6:0] M_40C0 = 7'h01;
  localparam logic [7:0] E_7FFF = 8'd127;
  localparam logic [6:0] M_7FFF = 7'h7F;
  localparam logic [6:0] M_5A5A = 7'h34;
  localparam logic [7:0] E_HI   = 8'd254;
  localparam logic [6:0] M_HI   = 7'h7F;
  localparam logic [2:0] F_HI   = 3'b000;
`endif

  typedef struct {
    logic [31:0] e;
    logic [27:0] m;
    logic [11:0] f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;
  int tog = 0;
  logic mon_en = 1'b0;
  logic [15:0] model_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    #1;
    case (rdy_mode)
      0: bus.out_ready = 1'b1;
      1: begin bus.out_ready = (tog % 3 == 0); tog++; end
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: checks the value produced by the last edge, then updates the
  // model for the edge to come.
  always @(negedge clk) begin : monitor
    logic        hold_v;
    logic [31:0] h_e;
    logic [27:0] h_m;
    logic [11:0] h_f;
    exp_t        x;
    int          n;
    #2;
    if (mon_en) begin
      chk("ovf_cnt", 64'(ovf_cnt), 64'(model_cnt));
      if (rst) begin
        model_cnt = '0;
        hold_v = 1'b0;
      end else begin
        if (hold_v && bus.out_valid) begin
          chk("stall_stable", {bus.out_e, bus.out_m, bus.out_flags}, {h_e, h_m, h_f});
        end
        if (!bus.in_ready) chk("in_ready_low_only_when_full", 64'(bus.out_valid && !bus.out_ready), 64'd1);
        hold_v = bus.out_valid && !bus.out_ready;
        h_e = bus.out_e; h_m = bus.out_m; h_f = bus.out_flags;
        if (bus.out_valid && bus.out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_beat", 64'(bus.out_e), 64'hDEAD);
          end else begin
            x = q.pop_front();
            chk("out_e", 64'(bus.out_e), 64'(x.e));
            chk("out_m", 64'(bus.out_m), 64'(x.m));
            chk("out_flags", 64'(bus.out_flags), 64'(x.f));
            n = 0;
            for (int i = 0; i < 4; i++) n += int'(x.f[i*3 + 2]);
            if (!cnt_clr) model_cnt = (int'(model_cnt) + n > 65535) ? 16'hFFFF : 16'(int'(model_cnt) + n);
          end
        end
        if (cnt_clr) model_cnt = '0;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic send(input logic [35:0] e, input logic [63:0] m,
                      input logic [31:0] oe, input logic [27:0] om, input logic [11:0] f);
    logic ok;
    exp_t x;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_e = e;
    bus.in_m = m;
    for (int t = 0; t < 200; t++) begin
      #4;
      ok = bus.in_ready;
      @(posedge clk);
      if (ok) begin
        x.e = oe; x.m = om; x.f = f;
        q.push_back(x);
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_v2();
    send({9'd127, 9'd254, 9'h100, 9'd50}, {16'h40C0, 16'h8000, 16'h1234, 16'h0000},
         {8'd127, 8'd255, 8'd255, 8'd0}, {M_40C0, 7'd0, 7'd0, 7'd0},
         {3'b000, 3'b100, 3'b100, 3'b001});
  endtask

  initial begin
    rst = 1'b1;
    cnt_clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_e = '0;
    bus.in_m = '0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", {bus.out_e, bus.out_m, bus.out_flags}, 64'd0);
    chk("rst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    #3;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'd1);

    // Directed vectors, lane 3 leftmost.
    send({9'd5, 9'd127, 9'd127, 9'd127}, {16'h0010, 16'h0001, 16'h8000, 16'h4000},
         {8'd0, 8'd113, 8'd128, 8'd127}, 28'd0, {3'b010, 3'b000, 3'b000, 3'b000});
    send_v2();
    send({9'd255, 9'd1, 9'd1, 9'd127}, {16'h8000, 16'h2000, 16'h4000, 16'h7FFF},
         {8'd255, 8'd0, 8'd1, E_7FFF}, {7'd0, 7'd0, 7'd0, M_7FFF},
         {3'b100, 3'b010, 3'b000, 3'b000});
    send({9'd140, 9'd254, 9'd100, 9'd200}, {16'hC000, 16'h7FFF, 16'h00FF, 16'h5A5A},
         {8'd141, E_HI, 8'd93, 8'd200}, {7'h40, M_HI, 7'h7F, M_5A5A},
         {3'b000, F_HI, 3'b000, 3'b000});
    send({9'd254, 9'd255, 9'd1, 9'd127}, {16'h4000, 16'h4000, 16'h0001, 16'h4040},
         {8'd254, 8'd255, 8'd0, 8'd127}, 28'd0, {3'b000, 3'b100, 3'b010, 3'b000});
    drain();

    // Backpressured stream: out_ready 1,0,0,1,...
    rdy_mode = 1;
    for (int k = 0; k < 10; k++) begin
      logic [35:0] e;
      logic [63:0] m;
      logic [31:0] oe;
      logic [27:0] om;
      for (int i = 0; i < 4; i++) begin
        e[i*9 +: 9]   = 9'(10 + 4*k + i);
        m[i*16 +: 16] = 16'h4000 | 16'(i << 7);
        oe[i*8 +: 8]  = 8'(10 + 4*k + i);
        om[i*7 +: 7]  = 7'(i);
      end
      send(e, m, oe, om, 12'h000);
    end
    drain();

    // Reset with two beats in flight.
    rdy_mode = 0;
    send_v2();
    drain();
    rdy_mode = 2;
    send_v2();
    send_v2();
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    #3;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_ovf_cnt", 64'(ovf_cnt), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    #3;
    chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);

    // cnt_clr coinciding with an overflow beat retiring.
    rdy_mode = 0;
    send_v2();
    drain();
    chk("ovf_cnt_before_clr", 64'(ovf_cnt), 64'd2);
    rdy_mode = 2;
    send_v2();
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rdy_mode = 0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    #3;
    chk("clr_wins_ovf_cnt", 64'(ovf_cnt), 64'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
